// File: rtl/vectorgen_pkg.sv
// Shared FSM encoding and lane-slicing helper for the vector generator.
package vectorgen_pkg;

  localparam int CNT_W = 64;

  typedef enum logic [7:0] {
    IDLE   = 8'd0,
    LEN    = 8'd1,
    WB     = 8'd2,
    BASE   = 8'd3,
    WS     = 8'd4,
    STRIDE = 8'd5,
    INIT   = 8'd6,
    STREAM = 8'd7,
    SUM    = 8'd8,
    CYC    = 8'd9
  } state_t;

  // Bit offset of lane idx inside a packed stream word of lanes that are width bits wide.
  function automatic int LANE_OFS(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/vectorgen_lane.sv
// One lane of the progression generator: loads its starting element, then strides by step.
module vectorgen_lane
  import vectorgen_pkg::*;
#(
  parameter int W_D      = 32,
  parameter int LANE_IDX = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic           adv,
  input  logic [W_D-1:0] base,
  input  logic [W_D-1:0] stride,
  input  logic [W_D-1:0] step,
  output logic [W_D-1:0] value
);

  localparam logic [W_D-1:0] LANE_MUL = W_D'(LANE_IDX);

  // Lane value: first element of this lane on init, then advance by the full word step per enqueue.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (init) begin
      value <= base + LANE_MUL * stride;
    end else if (adv) begin
      value <= value + step;
    end
  end

endmodule

// File: rtl/vectorgen_main.sv
// Arithmetic-progression vector producer: reads len/base/stride commands, streams words, reports checksums.
module vectorgen_main
  import vectorgen_pkg::*;
#(
  parameter int SIMD_WIDTH     = 4,
  parameter int LOG_SIMD_WIDTH = 2,
  parameter int W_D            = 32,
  parameter int W_COMM_D       = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic [W_D*SIMD_WIDTH-1:0] out_d,
  output logic                      out_enq,
  input  logic                      out_full,
  output logic [W_COMM_D-1:0]       comm_d,
  output logic                      comm_enq,
  input  logic                      comm_full,
  input  logic [W_COMM_D-1:0]       comm_q,
  output logic                      comm_deq,
  input  logic                      comm_empty
);

  state_t              state;
  state_t              state_next;
  logic                deq_next;
  logic                send_sum;
  logic                send_cyc;
  logic                lane_init;
  logic                lane_adv;
  logic                running;
  logic [CNT_W-1:0]    len;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cyclecount;
  logic [W_D-1:0]      base;
  logic [W_D-1:0]      stride;
  logic [W_D-1:0]      step;
  logic [W_COMM_D-1:0] checksum;
  logic [W_COMM_D-1:0] lane_sum;
  logic [W_D-1:0]      lane_val [SIMD_WIDTH];

  assign out_enq   = (state == STREAM) && !out_full;
  assign lane_init = (state == INIT);
  assign lane_adv  = out_enq;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the strobes that the datapath registers turn into channel pulses.
  always_comb begin
    state_next = state;
    deq_next   = 1'b0;
    send_sum   = 1'b0;
    send_cyc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!comm_empty) begin
          deq_next   = 1'b1;
          state_next = LEN;
        end
      end
      LEN:    state_next = (comm_q == '0) ? CYC : WB;
      WB: begin
        if (!comm_empty) begin
          deq_next   = 1'b1;
          state_next = BASE;
        end
      end
      BASE:   state_next = WS;
      WS: begin
        if (!comm_empty) begin
          deq_next   = 1'b1;
          state_next = STRIDE;
        end
      end
      STRIDE: state_next = INIT;
      INIT:   state_next = STREAM;
      STREAM: begin
        if (out_enq && (cnt == len - 64'd1)) begin
          state_next = SUM;
        end
      end
      SUM: begin
        if (!comm_full) begin
          send_sum   = 1'b1;
          state_next = IDLE;
        end
      end
      CYC: begin
        if (!comm_full) begin
          send_cyc   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Checksum adder tree: zero-extended sum of the lanes currently presented on out_d.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      lane_sum = lane_sum + W_COMM_D'(lane_val[i]);
    end
  end

  // Command capture, element counting, checksum accumulation, run timer and channel pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      comm_d     <= '0;
      comm_enq   <= 1'b0;
      comm_deq   <= 1'b0;
      running    <= 1'b0;
      len        <= '0;
      cnt        <= '0;
      base       <= '0;
      stride     <= '0;
      step       <= '0;
      checksum   <= '0;
      cyclecount <= '0;
    end else begin
      comm_deq   <= deq_next;
      comm_enq   <= send_sum | send_cyc;
      cyclecount <= running ? cyclecount + 64'd1 : '0;
      if (send_sum) begin
        comm_d <= checksum;
      end else if (send_cyc) begin
        comm_d <= cyclecount[W_COMM_D-1:0];
      end
      if ((state == IDLE) && deq_next) begin
        running <= 1'b1;
      end else if (send_cyc) begin
        running <= 1'b0;
      end
      if (state == LEN) begin
        len <= CNT_W'(comm_q);
        cnt <= '0;
      end
      if (state == BASE) begin
        base <= comm_q[W_D-1:0];
      end
      if (state == STRIDE) begin
        stride <= comm_q[W_D-1:0];
      end
      if (state == INIT) begin
        step     <= stride << LOG_SIMD_WIDTH;
        checksum <= '0;
      end
      if (lane_adv) begin
        checksum <= checksum + lane_sum;
        cnt      <= cnt + 64'd1;
      end
    end
  end

  // One lane generator per SIMD lane, each wired to its slice of the stream word.
  for (genvar g = 0; g < SIMD_WIDTH; g++) begin : g_lane
    vectorgen_lane #(
      .W_D     (W_D),
      .LANE_IDX(g)
    ) u_lane (
      .clk   (CLK),
      .rst   (RST),
      .init  (lane_init),
      .adv   (lane_adv),
      .base  (base),
      .stride(stride),
      .step  (step),
      .value (lane_val[g])
    );
    assign out_d[LANE_OFS(g, W_D) +: W_D] = lane_val[g];
  end

endmodule

// File: tb/tb_vectorgen_main.sv
// Self-checking bench for vectorgen_main: command channel model, element-indexed scoreboard, directed vectors.
module tb_vectorgen_main;

  logic         CLK;
  logic         RST;
  logic [127:0] out_d;
  logic         out_enq;
  logic         out_full;
  logic [31:0]  comm_d;
  logic         comm_enq;
  logic         comm_full;
  logic [31:0]  comm_q;
  logic         comm_deq;
  logic         comm_empty;

  vectorgen_main #(
    .SIMD_WIDTH    (4),
    .LOG_SIMD_WIDTH(2),
    .W_D           (32),
    .W_COMM_D      (32)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .out_d     (out_d),
    .out_enq   (out_enq),
    .out_full  (out_full),
    .comm_d    (comm_d),
    .comm_enq  (comm_enq),
    .comm_full (comm_full),
    .comm_q    (comm_q),
    .comm_deq  (comm_deq),
    .comm_empty(comm_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cmd_mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [127:0] exp_words [$];
  bit           exp_kind  [$];
  logic [31:0]  exp_sum   [$];

  int           cyc_idx       = 0;
  int           start_idx     = 0;
  bit           model_running = 0;
  int           words_seen    = 0;
  int           comm_count    = 0;
  logic [127:0] first_word    = '0;
  logic [127:0] last_word     = '0;
  logic [31:0]  last_comm     = '0;
  logic [31:0]  last_cyc      = '0;
  logic         prev_out_full = 1'b0;
  logic         prev_comm_full = 1'b0;
  logic [127:0] prev_out_d    = '0;

  assign comm_empty = (wr_ptr == rd_ptr);
  assign comm_q     = cmd_mem[rd_ptr[7:0]];

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // First-word-fall-through channel: the head is popped on the edge that sees the dequeue pulse.
  always @(posedge CLK) begin
    if (comm_deq && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [127:0] actual);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got 0x%0h, required nothing", name, actual);
  endtask

  // Element k of a vector is base + k*stride; word j carries elements 4j..4j+3, lane 0 lowest.
  function automatic logic [127:0] model_word(input logic [31:0] b, input logic [31:0] s, input int j);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = b + 32'(j*4 + i) * s;
    return w;
  endfunction

  function automatic logic [31:0] model_sum(input logic [31:0] b, input logic [31:0] s, input int n);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < n*4; k++) acc = acc + (b + 32'(k) * s);
    return acc;
  endfunction

  task automatic pushCmd(input logic [31:0] v);
    cmd_mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  // Queue one command on the channel and record what the generator owes for it.
  task automatic applyStimulus(input int n, input logic [31:0] b, input logic [31:0] s);
    pushCmd(32'(n));
    if (n != 0) begin
      pushCmd(b);
      pushCmd(s);
      for (int j = 0; j < n; j++) exp_words.push_back(model_word(b, s, j));
      exp_kind.push_back(1'b0);
      exp_sum.push_back(model_sum(b, s, n));
    end else begin
      exp_kind.push_back(1'b1);
      exp_sum.push_back(32'd0);
    end
  endtask

  task automatic resetDut();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    exp_words.delete();
    exp_kind.delete();
    exp_sum.delete();
    model_running = 0;
    @(negedge CLK);
    checkOutput("rst_out_d", out_d, 128'd0);
    checkOutput("rst_out_enq", {127'd0, out_enq}, 128'd0);
    checkOutput("rst_comm_d", {96'd0, comm_d}, 128'd0);
    checkOutput("rst_comm_enq", {127'd0, comm_enq}, 128'd0);
    checkOutput("rst_comm_deq", {127'd0, comm_deq}, 128'd0);
    #1;
    RST = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_words.size() != 0 || exp_kind.size() != 0) && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    n_checks++;
    if (exp_words.size() != 0 || exp_kind.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d words and %0d replies outstanding, required 0",
               name, exp_words.size(), exp_kind.size());
    end
    repeat (3) @(negedge CLK);
    #1;
  endtask

  task automatic waitWords(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (words_seen < target && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    checkOutput(name, 128'(words_seen >= target), 128'd1);
  endtask

  // Scoreboard: every enqueued word and channel reply is matched against the model, once per cycle.
  always @(negedge CLK) begin
    logic [127:0] ew;
    bit           kind;
    logic [31:0]  sv;
    cyc_idx++;
    if (!RST) begin
      if (comm_deq && !model_running) begin
        model_running = 1;
        start_idx     = cyc_idx;
      end
      if (out_enq) begin
        checkOutput("enq_while_full", {127'd0, out_full}, 128'd0);
        if (exp_words.size() == 0) reportUnexpected("extra_word", out_d);
        else begin
          ew = exp_words.pop_front();
          checkOutput("out_d", out_d, ew);
        end
        if (words_seen == 0) first_word = out_d;
        last_word = out_d;
        words_seen++;
      end
      if (comm_enq) begin
        checkOutput("enq_while_comm_full", {127'd0, prev_comm_full}, 128'd0);
        if (exp_kind.size() == 0) reportUnexpected("extra_reply", {96'd0, comm_d});
        else begin
          kind = exp_kind.pop_front();
          sv   = exp_sum.pop_front();
          if (kind) begin
            checkOutput("cyclecount", {96'd0, comm_d}, {96'd0, 32'(cyc_idx - start_idx - 1)});
            model_running = 0;
            last_cyc      = comm_d;
          end else begin
            checkOutput("checksum", {96'd0, comm_d}, {96'd0, sv});
            last_comm = comm_d;
          end
        end
        comm_count++;
      end
      if (out_full && prev_out_full) checkOutput("stall_out_d", out_d, prev_out_d);
    end
    prev_out_full  = out_full;
    prev_comm_full = comm_full;
    prev_out_d     = out_d;
  end

  // Hard stop in case the design wedges somewhere no bounded wait covers.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of command vectors.
  initial begin
    int c0;
    for (int i = 0; i < 256; i++) cmd_mem[i] = '0;
    RST       = 1'b1;
    out_full  = 1'b0;
    comm_full = 1'b0;
    resetDut();

    words_seen = 0;
    applyStimulus(4, 32'd10, 32'd3);
    waitDrain("len4", 200);
    checkOutput("len4_first_word", first_word, 128'h00000013_00000010_0000000D_0000000A);
    checkOutput("len4_checksum", {96'd0, last_comm}, 128'd520);

    words_seen = 0;
    applyStimulus(2, 32'd0, 32'd1);
    waitDrain("len2", 200);
    checkOutput("len2_first_word", first_word, 128'h00000003_00000002_00000001_00000000);
    checkOutput("len2_last_word", last_word, 128'h00000007_00000006_00000005_00000004);
    checkOutput("len2_checksum", {96'd0, last_comm}, 128'd28);

    words_seen = 0;
    applyStimulus(1, 32'hFFFF_FFFE, 32'd1);
    waitDrain("wrap", 200);
    checkOutput("wrap_word", first_word, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE);
    checkOutput("wrap_checksum", {96'd0, last_comm}, 128'hFFFF_FFFE);

    words_seen = 0;
    c0         = comm_count;
    comm_full  = 1'b1;
    applyStimulus(4, 32'd100, 32'd5);
    waitWords("bp_two_words", 2, 200);
    @(posedge CLK);
    #1;
    out_full = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    out_full = 1'b0;
    waitWords("bp_four_words", 4, 200);
    repeat (3) @(posedge CLK);
    #1;
    comm_full = 1'b0;
    waitDrain("backpressure", 200);
    checkOutput("bp_word_count", 128'(words_seen), 128'd4);
    checkOutput("bp_reply_count", 128'(comm_count - c0), 128'd1);

    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    exp_words.delete();
    exp_kind.delete();
    exp_sum.delete();
    model_running = 0;
    words_seen    = 0;
    c0            = comm_count;
    applyStimulus(1, 32'd7, 32'd2);
    applyStimulus(0, 32'd0, 32'd0);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    waitDrain("cyc", 200);
    checkOutput("cyc_value", {96'd0, last_cyc}, 128'd10);
    checkOutput("cyc_checksum", {96'd0, last_comm}, 128'd40);
    checkOutput("cyc_reply_count", 128'(comm_count - c0), 128'd2);

    words_seen = 0;
    c0         = comm_count;
    applyStimulus(4, 32'd0, 32'd1);
    waitWords("rst_two_words", 2, 200);
    resetDut();
    repeat (4) @(negedge CLK);
    #1;
    checkOutput("rst_no_reply", 128'(comm_count - c0), 128'd0);
    words_seen = 0;
    applyStimulus(1, 32'd5, 32'd1);
    waitDrain("after_rst", 200);
    checkOutput("after_rst_word", first_word, 128'h00000008_00000007_00000006_00000005);
    checkOutput("after_rst_checksum", {96'd0, last_comm}, 128'd26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
